param_shift_reg: RTL and testbench
==================================

# param_shift_reg

Parametrised multi-stage register: a WIDTH-bit, DEPTH-stage shift/delay line built from rising-edge D flip-flops. It is the generalisation of the team's single-bit DFF. It adds per-cycle enable, mode selection (hold, shift, parallel load, synchronous clear), and fill tracking. Fill status is reported through a level `Valid` and a one-cycle `Done` pulse. It sits in datapaths as a configurable pipeline delay or a sample buffer.

## Interface
- WIDTH, 8: bits per stage; must be at least 1.
- DEPTH, 4: number of stages; must be at least 2.
- Clk  input  1  clock; all state updates on the rising edge.
- Rst_n  input  1  asynchronous, active-low reset.
- En  input  1  cycle enable; when 0 the block holds regardless of Mode.
- Mode  input  2  operation select:
  - 00: hold
  - 01: shift in
  - 10: parallel load
  - 11: synchronous clear
- D  input  WIDTH  data in. Enters stage 0 on shift; is written to every stage on load.
- Q  output  WIDTH  stage DEPTH-1 (oldest data).
- Q_all  output  WIDTH*DEPTH  all stages; stage k occupies bits [k*WIDTH +: WIDTH].
- Valid  output  1  high while fill count equals DEPTH.
- Done  output  1  one-cycle pulse when the fill count first reaches DEPTH.

## Operation
- Storage:
  - DEPTH registers stage[0..DEPTH-1], each WIDTH bits.
  - fill_cnt, 0..DEPTH, of width clog2(DEPTH+1). It saturates at DEPTH and never wraps.
- Per rising edge of Clk with Rst_n=1:
  - En=0: all state held; Done forced to 0.
  - En=1, Mode=00: all state held; Done forced to 0.
  - En=1, Mode=01:
    - stage[0] <= D; stage[k] <= stage[k-1] for k=1..DEPTH-1.
    - fill_cnt <= min(fill_cnt+1, DEPTH).
  - En=1, Mode=10: every stage <= D; fill_cnt <= DEPTH.
  - En=1, Mode=11: every stage <= 0; fill_cnt <= 0.
- Done rule:
  - Done <= 1 only when the edge moves fill_cnt from a value below DEPTH to DEPTH.
  - Otherwise Done <= 0.
  - Shifting or loading while already full produces no pulse.
- Valid is combinational from fill_cnt: Valid = (fill_cnt == DEPTH).
- Q and Q_all are direct register outputs, with no combinational path from D.
- Reset: Rst_n=0 immediately, without a clock edge, clears:
  - all stages
  - fill_cnt
  - Done
  - therefore Q=0, Q_all=0, Valid=0.
- Reset mid-operation: partial fill is discarded. After release, DEPTH further shifts (or one load) are required before Done.
- Rst_n release is sampled synchronously: the first edge with Rst_n=1 performs a normal operation.

## Timing
- Latency in shift mode: D reaches Q after exactly DEPTH enabled shift edges. Hold and disabled cycles do not count.
- Load and clear take effect on the same edge; Q and Q_all are updated after that edge.
- Done and Valid rise together on the edge that completes the fill. Done falls on the next edge unconditionally.
- Valid stays high until a clear or reset.
- No handshake and no back-pressure: every enabled edge acts.

## Test plan
All scenarios use WIDTH=8, DEPTH=4.
1. Async reset: after loading 0xFF, drive Rst_n=0 between edges -> Q=0x00, Q_all=0x00000000, Valid=0, Done=0 before the next edge.
2. Fill by shifting: with En=1, Mode=01, shift D=0x11, 0x22, 0x33, 0x44 on four edges ->
   - after the 4th edge: Q=0x11, Q_all=0x11223344, Valid=1, Done=1 for exactly one cycle;
   - a 5th shift of D=0x55 -> Q=0x22, Done=0.
3. Load: from empty, one edge with Mode=10, D=0xA5 -> Q_all=0xA5A5A5A5, Valid=1, Done pulses once; a second load of D=0x3C -> Q_all=0x3C3C3C3C, Done stays 0.
4. Enable gating: from the full state, En=0 with Mode=01 for 3 edges, then En=1 with Mode=00 for 2 edges -> Q_all unchanged, Valid=1, Done=0 throughout.
5. Sync clear and refill: while full, one edge with Mode=11 -> Q_all=0, Valid=0; then four shifts -> Done pulses on the 4th edge only.
6. Reset mid-fill: shift two values, assert Rst_n=0 for half a cycle, release, then shift 0x01..0x04 -> Done pulses only on the 4th post-release shift, with Q=0x01.

Source files
------------

// File: rtl/param_shift_reg_if.sv
// Control, data and status bundle for param_shift_reg.
// The master drives the controls and data; the slave (the shift register) returns its state.
interface param_shift_reg_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
);

  logic                   en;
  logic [1:0]             mode;
  logic [WIDTH-1:0]       d;
  logic [WIDTH-1:0]       q;
  logic [WIDTH*DEPTH-1:0] q_all;
  logic                   valid;
  logic                   done;

  modport master (
    output en, mode, d,
    input  q, q_all, valid, done
  );

  modport slave (
    input  en, mode, d,
    output q, q_all, valid, done
  );

endinterface

// File: rtl/param_shift_reg.sv
// WIDTH-bit, DEPTH-stage shift/delay line with hold, shift, parallel-load and clear modes.
// A saturating fill counter drives the Valid level and the one-cycle Done pulse.
module param_shift_reg #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input logic               clk,
  input logic               rst_n,
  param_shift_reg_if.slave  bus
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  localparam logic [CntW-1:0] Full = CntW'(DEPTH);

  localparam logic [1:0] ModeHold  = 2'b00;
  localparam logic [1:0] ModeShift = 2'b01;
  localparam logic [1:0] ModeLoad  = 2'b10;
  localparam logic [1:0] ModeClear = 2'b11;

  // Packed so the stage array is already laid out as q_all (stage k at [k*WIDTH +: WIDTH]).
  logic [DEPTH-1:0][WIDTH-1:0] stage_q, stage_d;
  logic [CntW-1:0]             fill_q, fill_d;
  logic                        done_q, done_d;

  always_comb begin
    stage_d = stage_q;
    fill_d  = fill_q;
    if (bus.en) begin
      unique case (bus.mode)
        ModeHold: ;
        ModeShift: begin
          stage_d = {stage_q[DEPTH-2:0], bus.d};
          if (fill_q != Full) fill_d = fill_q + 1'b1;
        end
        ModeLoad: begin
          stage_d = {DEPTH{bus.d}};
          fill_d  = Full;
        end
        ModeClear: begin
          stage_d = '0;
          fill_d  = '0;
        end
        default: ;
      endcase
    end
    // Pulse only on the transition into full; staying full never re-fires.
    done_d = (fill_q != Full) && (fill_d == Full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stage_q <= '0;
      fill_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      fill_q  <= fill_d;
      done_q  <= done_d;
    end
  end

  assign bus.q     = stage_q[DEPTH-1];
  assign bus.q_all = stage_q;
  assign bus.valid = (fill_q == Full);
  assign bus.done  = done_q;

endmodule

// File: tb/tb_param_shift_reg.sv
// Directed bench for param_shift_reg at WIDTH=8, DEPTH=4 with hand-computed expectations.
module tb_param_shift_reg;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  param_shift_reg_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

  param_shift_reg #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge; outputs are then sampled 2 time units after it.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    bus.en  = 1'b0;
    bus.mode = 2'b00;
    bus.d   = '0;
    tick();
    tick();
    n_checks++;
    if (bus.q_all !== 32'h0) begin
      n_fail++; $display("FAIL reset_q_all: got %h expected %h", bus.q_all, 32'h0);
    end
    n_checks++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: got valid=%b done=%b expected 0 0", bus.valid, bus.done);
    end
    rst_n = 1'b1;
    bus.en = 1'b1;
    bus.mode = 2'b10;
    bus.d = 8'hFF;
    tick();
    n_checks++;
    if (bus.q_all !== 32'hFFFF_FFFF) begin
      n_fail++; $display("FAIL reset_preload: got %h expected %h", bus.q_all, 32'hFFFF_FFFF);
    end
    bus.en = 1'b0;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.q !== 8'h00 || bus.q_all !== 32'h0) begin
      n_fail++; $display("FAIL async_reset_data: got q=%h q_all=%h expected 00 0", bus.q, bus.q_all);
    end
    n_checks++;
    if (bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL async_reset_flags: got valid=%b done=%b expected 0 0",
                         bus.valid, bus.done);
    end
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_shift_fill();
    logic [7:0] vals [4];
    vals = '{8'h11, 8'h22, 8'h33, 8'h44};
    bus.en = 1'b1;
    bus.mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.d = vals[i];
      tick();
      n_checks++;
      if (bus.valid !== (i == 3) || bus.done !== (i == 3)) begin
        n_fail++; $display("FAIL shift_fill_flags[%0d]: got valid=%b done=%b expected %b %b",
                           i, bus.valid, bus.done, (i == 3), (i == 3));
      end
    end
    n_checks++;
    if (bus.q !== 8'h11 || bus.q_all !== 32'h1122_3344) begin
      n_fail++; $display("FAIL shift_fill_data: got q=%h q_all=%h expected 11 11223344",
                         bus.q, bus.q_all);
    end
    bus.d = 8'h55;
    tick();
    n_checks++;
    if (bus.q !== 8'h22 || bus.q_all !== 32'h2233_4455) begin
      n_fail++; $display("FAIL shift_fifth_data: got q=%h q_all=%h expected 22 22334455",
                         bus.q, bus.q_all);
    end
    n_checks++;
    if (bus.done !== 1'b0 || bus.valid !== 1'b1) begin
      n_fail++; $display("FAIL shift_fifth_flags: got done=%b valid=%b expected 0 1",
                         bus.done, bus.valid);
    end
  endtask

  task automatic test_load();
    bus.en = 1'b1;
    bus.mode = 2'b11;
    tick();
    n_checks++;
    if (bus.valid !== 1'b0 || bus.q_all !== 32'h0) begin
      n_fail++; $display("FAIL load_preclear: got valid=%b q_all=%h expected 0 0",
                         bus.valid, bus.q_all);
    end
    bus.mode = 2'b10;
    bus.d = 8'hA5;
    tick();
    n_checks++;
    if (bus.q_all !== 32'hA5A5_A5A5 || bus.valid !== 1'b1 || bus.done !== 1'b1) begin
      n_fail++; $display("FAIL load_first: got q_all=%h valid=%b done=%b expected a5a5a5a5 1 1",
                         bus.q_all, bus.valid, bus.done);
    end
    bus.d = 8'h3C;
    tick();
    n_checks++;
    if (bus.q_all !== 32'h3C3C_3C3C || bus.valid !== 1'b1 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL load_second: got q_all=%h valid=%b done=%b expected 3c3c3c3c 1 0",
                         bus.q_all, bus.valid, bus.done);
    end
  endtask

  task automatic test_enable_gating();
    bus.en = 1'b0;
    bus.mode = 2'b01;
    bus.d = 8'h77;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) begin
        bus.en = 1'b1;
        bus.mode = 2'b00;
      end
      tick();
      n_checks++;
      if (bus.q_all !== 32'h3C3C_3C3C || bus.valid !== 1'b1 || bus.done !== 1'b0) begin
        n_fail++; $display("FAIL gate_hold[%0d]: got q_all=%h valid=%b done=%b expected 3c3c3c3c 1 0",
                           i, bus.q_all, bus.valid, bus.done);
      end
    end
  endtask

  task automatic test_clear_refill();
    bus.en = 1'b1;
    bus.mode = 2'b11;
    tick();
    n_checks++;
    if (bus.q_all !== 32'h0 || bus.valid !== 1'b0 || bus.done !== 1'b0) begin
      n_fail++; $display("FAIL clear: got q_all=%h valid=%b done=%b expected 0 0 0",
                         bus.q_all, bus.valid, bus.done);
    end
    bus.mode = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bus.d = 8'(8'h0A + i);
      tick();
      n_checks++;
      if (bus.done !== (i == 3) || bus.valid !== (i == 3)) begin
        n_fail++; $display("FAIL refill_flags[%0d]: got done=%b valid=%b expected %b %b",
                           i, bus.done, bus.valid, (i == 3), (i == 3));
      end
    end
    n_checks++;
    if (bus.q_all !== 32'h0A0B_0C0D) begin
      n_fail++; $display("FAIL refill_data: got %h expected %h", bus.q_all, 32'h0A0B_0C0D);
    end
  endtask

  task automatic test_reset_mid_fill();
    bus.en = 1'b1;
    bus.mode = 2'b11;
    tick();
    bus.mode = 2'b01;
    bus.d = 8'hEE;
    tick();
    bus.d = 8'hDD;
    tick();
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (bus.q_all !== 32'h0) begin
      n_fail++; $display("FAIL midfill_reset: got %h expected %h", bus.q_all, 32'h0);
    end
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.d = 8'(i + 1);
      tick();
      n_checks++;
      if (bus.done !== (i == 3) || bus.valid !== (i == 3)) begin
        n_fail++; $display("FAIL midfill_refill[%0d]: got done=%b valid=%b expected %b %b",
                           i, bus.done, bus.valid, (i == 3), (i == 3));
      end
    end
    n_checks++;
    if (bus.q !== 8'h01 || bus.q_all !== 32'h0102_0304) begin
      n_fail++; $display("FAIL midfill_data: got q=%h q_all=%h expected 01 01020304",
                         bus.q, bus.q_all);
    end
    bus.mode = 2'b00;
    tick();
    n_checks++;
    if (bus.done !== 1'b0) begin
      n_fail++; $display("FAIL midfill_done_fall: got %b expected 0", bus.done);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail = 0;
    test_reset();
    test_shift_fill();
    test_load();
    test_enable_gating();
    test_clear_refill();
    test_reset_mid_fill();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
